// File: rtl/matmul_compute_ctrl_if.sv
// Purpose : bus between the compute-phase sequencer and the memory/MAC datapath.
//           Groups the load/ready handshake, the shared dimension K, the A/B read
//           addresses, the MAC strobes and the completion pulses.
// Ports   : none; clock and reset stay plain ports on the modules.
//   master : sequencer side. It samples matrices_loaded, K and out_ready.
//            It drives the addresses, mac_valid/mac_init, result_valid and compute_finished.
//   slave  : datapath / environment side, with the opposite directions.
interface matmul_compute_ctrl_if #(
   parameter int M    = 7,
   parameter int N    = 9,
   parameter int MAXK = 8
);
   localparam int K_BITS      = $clog2(MAXK + 1);
   localparam int A_ADDR_BITS = $clog2(M * MAXK);
   localparam int B_ADDR_BITS = $clog2(MAXK * N);

   logic                   matrices_loaded;
   logic [K_BITS-1:0]      K;
   logic                   out_ready;
   logic [A_ADDR_BITS-1:0] A_read_addr;
   logic [B_ADDR_BITS-1:0] B_read_addr;
   logic                   mac_valid;
   logic                   mac_init;
   logic                   result_valid;
   logic                   compute_finished;

   modport master (
      input  matrices_loaded, K, out_ready,
      output A_read_addr, B_read_addr, mac_valid, mac_init, result_valid, compute_finished
   );

   modport slave (
      output matrices_loaded, K, out_ready,
      input  A_read_addr, B_read_addr, mac_valid, mac_init, result_valid, compute_finished
   );
endinterface

// File: rtl/matmul_compute_ctrl.sv
// Purpose : sequences the compute phase of the matrix-multiply accelerator.
//           It walks every C[m][n] in row-major order. For each element it issues
//           K (A,B) read-address pairs, one pair per cycle. MAC strobes are aligned
//           to the 1-cycle memory read latency, and each finished dot product is
//           flagged. The run ends with a one-cycle compute_finished pulse.
// Ports   :
//   clk   : rising-edge clock.
//   reset : synchronous, active-high.
//   bus   : matmul_compute_ctrl_if.master. Inputs are matrices_loaded, K and
//           out_ready. Outputs are A_read_addr, B_read_addr, mac_valid, mac_init,
//           result_valid and compute_finished. All outputs are registered.
module matmul_compute_ctrl #(
   parameter int M       = 7,
   parameter int N       = 9,
   parameter int MAXK    = 8,
   parameter int MAC_LAT = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   matmul_compute_ctrl_if.master bus
);
   localparam int K_BITS      = $clog2(MAXK + 1);
   localparam int A_ADDR_BITS = $clog2(M * MAXK);
   localparam int B_ADDR_BITS = $clog2(MAXK * N);
   localparam int M_BITS      = (M > 1) ? $clog2(M) : 1;
   localparam int N_BITS      = (N > 1) ? $clog2(N) : 1;
   localparam int DL          = 1 + MAC_LAT;

   localparam logic [M_BITS-1:0]      M_LAST = M_BITS'(M - 1);
   localparam logic [N_BITS-1:0]      N_LAST = N_BITS'(N - 1);
   localparam logic [B_ADDR_BITS-1:0] N_STEP = B_ADDR_BITS'(N);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_OUT = 3'd1,
      S_ISSUE    = 3'd2,
      S_DRAIN    = 3'd3,
      S_DONE     = 3'd4,
      S_WAIT_CLR = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic [K_BITS-1:0]      kval_q, kval_d;
   logic [K_BITS-1:0]      k_q, k_d;
   logic [M_BITS-1:0]      m_q, m_d;
   logic [N_BITS-1:0]      n_q, n_d;
   logic [A_ADDR_BITS-1:0] a_base_q, a_base_d;
   logic [A_ADDR_BITS-1:0] a_addr_q, a_addr_d;
   logic [B_ADDR_BITS-1:0] b_addr_q, b_addr_d;
   // Result delay line: stage 0 is what the MAC sees this cycle.
   // The last stage marks a completed sum.
   logic [DL-1:0]          dl_valid_q, dl_last_q;
   // Only stage 0 of the init flag is ever consumed, so it is a single stage.
   logic                   dl_init_q;
   logic                   fin_q;

   logic issue_s;
   logic k_last_s;
   logic last_elem_s;
   logic pending_s;

   assign issue_s     = (state_q == S_ISSUE);
   assign k_last_s    = (k_q == (kval_q - K_BITS'(1)));
   assign last_elem_s = (m_q == M_LAST) && (n_q == N_LAST);
   // Issues still in flight that have not yet reached the final stage.
   assign pending_s   = |dl_valid_q[DL-2:0];

   // Next-state, counter and address logic.
   // The address registers are loaded one cycle ahead so that, during every
   // ISSUE cycle, they already hold that cycle's pair. Outside ISSUE they hold
   // their last value.
   always_comb begin
      state_d  = state_q;
      kval_d   = kval_q;
      k_d      = k_q;
      m_d      = m_q;
      n_d      = n_q;
      a_base_d = a_base_q;
      a_addr_d = a_addr_q;
      b_addr_d = b_addr_q;
      case (state_q)
         S_IDLE: begin
            if (bus.matrices_loaded) begin
               kval_d   = bus.K;
               k_d      = '0;
               m_d      = '0;
               n_d      = '0;
               a_base_d = '0;
               if (bus.K == K_BITS'(0)) begin
                  state_d = S_DONE;
               end else if (bus.out_ready) begin
                  state_d  = S_ISSUE;
                  a_addr_d = '0;
                  b_addr_d = '0;
               end else begin
                  state_d = S_WAIT_OUT;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT_OUT: begin
            if (bus.out_ready) begin
               state_d  = S_ISSUE;
               a_addr_d = a_base_q;
               b_addr_d = B_ADDR_BITS'(n_q);
            end else begin
               state_d = S_WAIT_OUT;
            end
         end
         S_ISSUE: begin
            if (!k_last_s) begin
               // Inside a dot product: step k, which steps A by 1 and B by one row of B.
               k_d      = k_q + K_BITS'(1);
               a_addr_d = a_addr_q + A_ADDR_BITS'(1);
               b_addr_d = b_addr_q + N_STEP;
            end else if (last_elem_s) begin
               state_d = S_DRAIN;
            end else begin
               k_d = '0;
               if (n_q == N_LAST) begin
                  // New row of C: the A base moves by K, so no multiplier is needed.
                  n_d      = '0;
                  m_d      = m_q + M_BITS'(1);
                  a_base_d = a_base_q + A_ADDR_BITS'(kval_q);
               end else begin
                  n_d = n_q + N_BITS'(1);
               end
               if (bus.out_ready) begin
                  state_d  = S_ISSUE;
                  a_addr_d = a_base_d;
                  b_addr_d = B_ADDR_BITS'(n_d);
               end else begin
                  state_d = S_WAIT_OUT;
               end
            end
         end
         S_DRAIN: begin
            // Leave as the final result reaches the last stage.
            // The finish pulse then lands one cycle after result_valid.
            if (!pending_s) begin
               state_d = S_DONE;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DONE: begin
            state_d = S_WAIT_CLR;
         end
         S_WAIT_CLR: begin
            // Wait for the load level to drop, so a stale level cannot relaunch the run.
            if (!bus.matrices_loaded) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_WAIT_CLR;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, counters, addresses, delay line and finish pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         kval_q     <= '0;
         k_q        <= '0;
         m_q        <= '0;
         n_q        <= '0;
         a_base_q   <= '0;
         a_addr_q   <= '0;
         b_addr_q   <= '0;
         dl_valid_q <= '0;
         dl_last_q  <= '0;
         dl_init_q  <= 1'b0;
         fin_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         kval_q     <= kval_d;
         k_q        <= k_d;
         m_q        <= m_d;
         n_q        <= n_d;
         a_base_q   <= a_base_d;
         a_addr_q   <= a_addr_d;
         b_addr_q   <= b_addr_d;
         dl_valid_q <= {dl_valid_q[DL-2:0], issue_s};
         dl_last_q  <= {dl_last_q[DL-2:0], issue_s & k_last_s};
         dl_init_q  <= issue_s & (k_q == K_BITS'(0));
         fin_q      <= (state_d == S_DONE);
      end
   end

   assign bus.A_read_addr      = a_addr_q;
   assign bus.B_read_addr      = b_addr_q;
   assign bus.mac_valid        = dl_valid_q[0];
   assign bus.mac_init         = dl_init_q;
   assign bus.result_valid     = dl_valid_q[DL-1] & dl_last_q[DL-1];
   assign bus.compute_finished = fin_q;
endmodule

// File: tb/tb_matmul_compute_ctrl.sv
module tb_matmul_compute_ctrl;
   localparam int M       = 7;
   localparam int N       = 9;
   localparam int MAXK    = 8;
   localparam int MAC_LAT = 1;
   localparam int K_BITS  = $clog2(MAXK + 1);

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   matmul_compute_ctrl_if #(.M(M), .N(N), .MAXK(MAXK)) bus ();

   matmul_compute_ctrl #(.M(M), .N(N), .MAXK(MAXK), .MAC_LAT(MAC_LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int a;
      int b;
      bit init;
      bit last;
   } issue_t;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Behavioural model state: the expected issue sequence and the cycles at which results are due.
   issue_t exp_q[$];
   int     rv_due[$];
   int     exp_results;
   bit     chk_en  = 1'b0;
   bit     k0_mode = 1'b0;
   bit     in_dp   = 1'b0;
   int     fin_cycle = -1;
   int     n_mac, n_rv, first_mac, last_mac;
   int     rv_cyc[$];
   int     init_cyc[$];
   int     obs_a[$];
   int     obs_b[$];
   int     prev_a, prev_b;
   int     raise_cyc, n_init_at_raise;

   task automatic check(input string name, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Expected issue order, built straight from the definition of C = A x B.
   task automatic build_model(input int k);
      issue_t e;
      exp_q.delete();
      rv_due.delete();
      rv_cyc.delete();
      init_cyc.delete();
      obs_a.delete();
      obs_b.delete();
      for (int m = 0; m < M; m++) begin
         for (int n = 0; n < N; n++) begin
            for (int kk = 0; kk < k; kk++) begin
               e.a    = m * k + kk;
               e.b    = kk * N + n;
               e.init = (kk == 0);
               e.last = (kk == k - 1);
               exp_q.push_back(e);
            end
         end
      end
      exp_results = (k == 0) ? 0 : M * N;
      n_mac     = 0;
      n_rv      = 0;
      first_mac = 0;
      last_mac  = 0;
      fin_cycle = -1;
      in_dp     = 1'b0;
      k0_mode   = (k == 0);
   endtask

   // Compare process: every cycle, check the DUT outputs against the model.
   always @(negedge clk) begin
      issue_t e;
      bit     exp_rv;
      cyc++;
      if (chk_en) begin
         if (bus.mac_valid && exp_q.size() == 0) begin
            check("spurious_mac_valid", bus.mac_valid, 0);
         end else if (bus.mac_valid) begin
            e = exp_q.pop_front();
            // Addresses were presented one cycle before the MAC sees the data.
            check("A_read_addr", prev_a, e.a);
            check("B_read_addr", prev_b, e.b);
            check("mac_init", bus.mac_init, e.init);
            obs_a.push_back(prev_a);
            obs_b.push_back(prev_b);
            n_mac++;
            if (n_mac == 1) first_mac = cyc;
            last_mac = cyc;
            if (e.init) init_cyc.push_back(cyc);
            in_dp = !e.last;
            if (e.last) rv_due.push_back(cyc + MAC_LAT);
         end else begin
            check("mac_init_without_valid", bus.mac_init, 0);
            if (in_dp) begin
               check("no_stall_inside_dot_product", bus.mac_valid, 1);
               in_dp = 1'b0;
            end
         end
         exp_rv = (rv_due.size() > 0) && (rv_due[0] == cyc);
         if (exp_rv) void'(rv_due.pop_front());
         check("result_valid", bus.result_valid, exp_rv);
         if (bus.result_valid) begin
            n_rv++;
            rv_cyc.push_back(cyc);
            if (exp_rv && n_rv == exp_results) fin_cycle = cyc + 1;
         end
         if (!k0_mode) check("compute_finished", bus.compute_finished, cyc == fin_cycle);
      end
      prev_a = bus.A_read_addr;
      prev_b = bus.B_read_addr;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_A_addr"}, bus.A_read_addr, 0);
      check({tag, "_B_addr"}, bus.B_read_addr, 0);
      check({tag, "_mac_valid"}, bus.mac_valid, 0);
      check({tag, "_mac_init"}, bus.mac_init, 0);
      check({tag, "_result_valid"}, bus.result_valid, 0);
      check({tag, "_compute_finished"}, bus.compute_finished, 0);
   endtask

   // One full run. Optionally, out_ready is dropped for 8 cycles during the 2nd dot product.
   task automatic run(input int k, input bit do_drop);
      bit dropped  = 1'b0;
      int drop_cnt = 0;
      int budget   = 0;
      build_model(k);
      chk_en              = 1'b1;
      bus.K               = K_BITS'(k);
      bus.matrices_loaded = 1'b1;
      bus.out_ready       = 1'b1;
      while (!bus.compute_finished && budget < 3000) begin
         tick();
         budget++;
         if (do_drop && !dropped && init_cyc.size() == 2) begin
            bus.out_ready = 1'b0;
            dropped       = 1'b1;
         end else if (dropped && !bus.out_ready) begin
            drop_cnt++;
            if (drop_cnt == 8) begin
               bus.out_ready   = 1'b1;
               raise_cyc       = cyc;
               n_init_at_raise = init_cyc.size();
            end
         end
      end
      check("finish_seen_before_timeout", bus.compute_finished, 1);
      if (k == 0) begin
         check("k0_finish_within_2_cycles", budget <= 2, 1);
         tick();
         check("k0_finish_single_cycle", bus.compute_finished, 0);
      end
      check("results_count", n_rv, exp_results);
      check("issues_left", exp_q.size(), 0);
      // Hold the load level after completion: the compare process flags any relaunch.
      repeat (3) tick();
      bus.matrices_loaded = 1'b0;
      repeat (4) tick();
   endtask

   int lit_a[4] = '{0, 1, 0, 1};
   int lit_b[4] = '{0, 9, 1, 10};

   initial begin
      reset               = 1'b1;
      bus.matrices_loaded = 1'b0;
      bus.K               = '0;
      bus.out_ready       = 1'b0;
      repeat (3) tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      // Pin the model with hand-computed values for K=2 and K=8.
      build_model(2);
      for (int i = 0; i < 4; i++) begin
         check("model_k2_A", exp_q[i].a, lit_a[i]);
         check("model_k2_B", exp_q[i].b, lit_b[i]);
      end
      check("model_k2_last_A", exp_q[exp_q.size() - 1].a, 13);
      check("model_k2_last_B", exp_q[exp_q.size() - 1].b, 17);
      build_model(8);
      check("model_k8_len", exp_q.size(), 504);
      check("model_k8_last_A", exp_q[503].a, 55);
      check("model_k8_last_B", exp_q[503].b, 71);

      // K=2, out_ready held high.
      run(2, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("k2_obs_A", obs_a[i], lit_a[i]);
         check("k2_obs_B", obs_b[i], lit_b[i]);
      end
      check("k2_init_every_2nd", init_cyc[1] - init_cyc[0], 2);

      // K=8: no bubbles, results spaced 8 cycles apart, final addresses.
      run(8, 1'b0);
      check("k8_mac_count", n_mac, 504);
      check("k8_consecutive", last_mac - first_mac + 1, 504);
      check("k8_rv_count", rv_cyc.size(), 63);
      for (int i = 1; i < rv_cyc.size(); i++) check("k8_rv_spacing", rv_cyc[i] - rv_cyc[i-1], 8);
      check("k8_last_A", obs_a[obs_a.size() - 1], 55);
      check("k8_last_B", obs_b[obs_b.size() - 1], 71);

      // K=0: no work, only a finish pulse.
      run(0, 1'b0);
      check("k0_mac_count", n_mac, 0);

      // out_ready dropped during the 2nd dot product.
      run(4, 1'b1);
      check("drop_no_init_while_low", n_init_at_raise, 2);
      check("drop_init_after_raise", init_cyc[2] - raise_cyc, 3);
      check("drop_rv_count", n_rv, 63);

      // Reset in the middle of ISSUE.
      build_model(3);
      chk_en              = 1'b1;
      bus.K               = K_BITS'(3);
      bus.matrices_loaded = 1'b1;
      bus.out_ready       = 1'b1;
      repeat (10) tick();
      check("abort_was_mid_issue", n_mac > 0, 1);
      chk_en              = 1'b0;
      reset               = 1'b1;
      bus.matrices_loaded = 1'b0;
      tick();
      check_all_zero("midrun_reset");
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_abort_result_valid", bus.result_valid, 0);
         check("post_abort_finished", bus.compute_finished, 0);
      end
      run(3, 1'b0);
      check("fresh_first_A", obs_a[0], 0);
      check("fresh_first_B", obs_b[0], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
